fifo_mem_controller: RTL
========================

Name: fifo_mem_controller

Overview:
- Sequences one dual_port_memory instance (Clock-synchronous write port, registered read port) as a circular FIFO.
- Owns the write and read pointers, occupancy count and status flags, and drives the memory's iWriteEnable, iWriteAddress and iReadAddress0.
- Generates oDataValid aligned with the memory's registered oDataOut0. The data path does not pass through this block.

Parameters:
- ADDR_WIDTH, 3, pointer/address width. FIFO depth DEPTH = 2**ADDR_WIDTH; the attached memory uses MEM_SIZE = DEPTH-1.
- ALMOST_FULL, 6, oAlmostFull asserts when count >= ALMOST_FULL.
- ALMOST_EMPTY, 2, oAlmostEmpty asserts when count <= ALMOST_EMPTY.

Ports:
- Clock  input  1  single clock, rising edge.
- Reset  input  1  asynchronous, active-high.
- iPush  input  1  write request; the memory iDataIn must hold valid data in the same cycle.
- iPop  input  1  read request.
- iFlush  input  1  synchronous empty.
- iClearErrors  input  1  synchronous clear of the sticky error flags.
- oMemWriteEnable  output  1  to memory iWriteEnable.
- oMemWriteAddress  output  ADDR_WIDTH  to memory iWriteAddress.
- oMemReadAddress  output  ADDR_WIDTH  to memory iReadAddress0.
- oDataValid  output  1  memory oDataOut0 holds popped data this cycle.
- oFull  output  1  count == DEPTH.
- oEmpty  output  1  count == 0.
- oAlmostFull  output  1  count >= ALMOST_FULL.
- oAlmostEmpty  output  1  count <= ALMOST_EMPTY.
- oCount  output  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- oOverflow  output  1  sticky: a push was rejected.
- oUnderflow  output  1  sticky: a pop was rejected.

Behaviour:
Registers:
- wr_ptr, rd_ptr (ADDR_WIDTH), count (ADDR_WIDTH+1), oDataValid, oOverflow, oUnderflow.
- Reset asserted: all registers clear immediately.
- Outputs during reset: oEmpty=1, oAlmostEmpty=1, oFull=0, oAlmostFull=0, oCount=0, oDataValid=0, oOverflow=0, oUnderflow=0, oMemWriteEnable=0, both addresses 0.

Acceptance (combinational, current cycle):
- push_ok = iPush & ~oFull & ~iFlush
- pop_ok = iPop & ~oEmpty & ~iFlush
- Full plus a simultaneous push and pop: the pop is accepted and the push is rejected.
- Empty plus a simultaneous push and pop: the push is accepted and the pop is rejected.

Memory drive:
- oMemWriteEnable = push_ok.
- oMemWriteAddress = wr_ptr.
- oMemReadAddress = rd_ptr, presented every cycle.

Rising edge, when not in reset and iFlush=0:
- push_ok: wr_ptr <= wr_ptr+1, wrapping from DEPTH-1 to 0.
- pop_ok: rd_ptr <= rd_ptr+1, with the same wrap.
- count: +1 on push only, -1 on pop only, unchanged when both or neither.
- oDataValid <= pop_ok.
- iPush & ~push_ok sets oOverflow. iPop & ~pop_ok sets oUnderflow.
- iClearErrors clears both error flags. Setting has priority over clearing in the same cycle.

Latency and ordering:
- Pop latency is 1 cycle. The memory captures Ram[rd_ptr] on the same edge that accepts the pop, so oDataOut0 and oDataValid are valid for exactly the following cycle.
- Back-to-back pops give one word per cycle.
- Write-to-read latency: a word pushed at edge N is poppable from edge N+1, with oEmpty deasserting after edge N.
- Because a pop on empty is rejected, the read port never reads the address being written on the same edge.

Flush:
- iFlush=1 at an edge sets wr_ptr, rd_ptr, count and oDataValid to 0.
- No memory write occurs that cycle; iPush and iPop are ignored without setting error flags.
- iFlush does not clear the error flags.

Status outputs:
- oFull, oEmpty, oAlmostFull and oAlmostEmpty are decoded from the count register, with no extra latency.
- oCount = count.

Reset mid-operation:
- Everything clears asynchronously; any in-flight oDataValid drops.
- Memory contents are not cleared and are don't-care.

Test Plan:
- Reset, then push 3 words (0x11, 0x22, 0x33) on consecutive cycles -> write addresses 0, 1, 2; oCount=3; oEmpty=0; oAlmostEmpty=0 after the 3rd push.
- Pop 3 consecutive cycles -> oDataValid high for 3 cycles, each starting 1 cycle after its pop; data 0x11, 0x22, 0x33; oEmpty=1 afterwards; a 4th pop sets oUnderflow with count still 0.
- Push 8 words -> oFull=1, oAlmostFull from count 6. A 9th push -> oMemWriteEnable=0, oOverflow=1, wr_ptr unchanged. iClearErrors -> oOverflow=0.
- Full FIFO, push and pop together -> pop accepted, push rejected; count=7; oOverflow=1. Empty FIFO, push and pop together -> count=1, oUnderflow=1, oDataValid=0 next cycle.
- Fill 5 words, pop 5, push 6 -> write addresses wrap 7 to 0; pops return the data in order across the wrap.
- 4 words stored, assert iFlush together with iPush -> count=0, oEmpty=1, no write, no error flag. Assert Reset asynchronously mid-pop -> oDataValid=0 immediately.

Source files
------------

// File: rtl/fifo_mem_controller.sv
// Pointer, occupancy and status sequencer that runs an external dual-port RAM
// as a circular FIFO; the data path stays in the RAM, only control lives here.
module fifo_mem_controller #(
  parameter int ADDR_WIDTH   = 3,
  parameter int ALMOST_FULL  = 6,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iPush,
  input  logic                  iPop,
  input  logic                  iFlush,
  input  logic                  iClearErrors,
  output logic                  oMemWriteEnable,
  output logic [ADDR_WIDTH-1:0] oMemWriteAddress,
  output logic [ADDR_WIDTH-1:0] oMemReadAddress,
  output logic                  oDataValid,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic                  oAlmostFull,
  output logic                  oAlmostEmpty,
  output logic [ADDR_WIDTH:0]   oCount,
  output logic                  oOverflow,
  output logic                  oUnderflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
  logic                  full, empty, push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  // Full favours the pop and empty favours the push, so the read port never
  // targets the word being written on the same edge.
  assign push_ok = iPush & ~full  & ~iFlush;
  assign pop_ok  = iPop  & ~empty & ~iFlush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (iFlush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      valid_d = pop_ok;
      ovf_d   = (iPush & ~push_ok) | (ovf_q & ~iClearErrors);
      unf_d   = (iPop  & ~pop_ok)  | (unf_q & ~iClearErrors);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign oMemWriteEnable  = push_ok;
  assign oMemWriteAddress = wr_ptr_q;
  assign oMemReadAddress  = rd_ptr_q;
  assign oDataValid       = valid_q;
  assign oFull            = full;
  assign oEmpty           = empty;
  assign oAlmostFull      = (count_q >= CW'(ALMOST_FULL));
  assign oAlmostEmpty     = (count_q <= CW'(ALMOST_EMPTY));
  assign oCount           = count_q;
  assign oOverflow        = ovf_q;
  assign oUnderflow       = unf_q;

endmodule
